// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the shared ALU arbiter: request/operand inputs and
// grant/done/result/busy status back to the two clients.
interface alu_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
);
    logic             req0;
    logic             req1;
    logic [SEL_W-1:0] op0;
    logic [SEL_W-1:0] op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic             busy;
    logic [WIDTH-1:0] result;

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        input  gnt0, gnt1, done0, done1, busy, result
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        output gnt0, gnt1, done0, done1, busy, result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter/sequencer for an external combinational ALU.
// Optional per-port completion counters cnt0/cnt1 when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [SEL_W-1:0] alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_f
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             owner_reg;
    logic             prio_reg;
    logic             winner;
    logic [SEL_W-1:0] alu_s_reg;
    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;
    logic [WIDTH-1:0] result_reg;

    // With both requesting the pointer decides; otherwise the lone requester wins.
    assign winner = (bus.req0 && bus.req1) ? prio_reg : bus.req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.req0 || bus.req1) state_next = ISSUE;
            ISSUE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant/done are decoded from state and owner so they cannot disagree.
    always_comb begin
        bus.busy  = (state_reg != IDLE);
        bus.gnt0  = (state_reg != IDLE) && !owner_reg;
        bus.gnt1  = (state_reg != IDLE) &&  owner_reg;
        bus.done0 = (state_reg == DONE) && !owner_reg;
        bus.done1 = (state_reg == DONE) &&  owner_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg  <= 1'b0;
            prio_reg   <= 1'b0;
            alu_s_reg  <= '0;
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner_reg <= winner;
                        alu_s_reg <= winner ? bus.op1 : bus.op0;
                        alu_a_reg <= winner ? bus.a1  : bus.a0;
                        alu_b_reg <= winner ? bus.b1  : bus.b0;
                    end
                end
                ISSUE: result_reg <= alu_f;
                DONE:  prio_reg   <= ~owner_reg;
                default: ;
            endcase
        end
    end

    assign alu_s      = alu_s_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign bus.result = result_reg;

`ifdef ALU_ARB_STATS_EN
    // Counted on the edge that raises done, so the count is visible with the pulse.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [7:0] cnt_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= 8'd0;
            end else if (state_reg == ISSUE && owner_reg == 1'(gi) && cnt_reg != 8'hFF) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end
    assign cnt0 = g_cnt[0].cnt_reg;
    assign cnt1 = g_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model with
// per-cycle comparison, directed literal checks and randomized requesters.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] alu_s;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_f;
`ifdef ALU_ARB_STATS_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
`endif

    alu_arbiter_if #(.WIDTH(4), .SEL_W(3)) bus ();

    alu_arbiter #(.WIDTH(4), .SEL_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .alu_s (alu_s),
        .alu_a (alu_a),
        .alu_b (alu_b),
        .alu_f (alu_f)
`ifdef ALU_ARB_STATS_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    // ALU stub: sum modulo 16, select ignored.
    assign alu_f = alu_a + alu_b;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Reference model: an op is described by its age since grant (0 = no op).
    int         m_age = 0;
    bit         m_owner = 1'b0;
    bit         m_prio = 1'b0;
    int         m_s = 0, m_a = 0, m_b = 0, m_result = 0;
    int         m_cnt0 = 0, m_cnt1 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age = 0; m_owner = 0; m_prio = 0;
            m_s = 0; m_a = 0; m_b = 0; m_result = 0;
            m_cnt0 = 0; m_cnt1 = 0;
        end else if (m_age == 0) begin
            if (bus.req0 || bus.req1) begin
                m_owner = (bus.req0 && bus.req1) ? m_prio : bus.req1;
                m_s = m_owner ? int'(bus.op1) : int'(bus.op0);
                m_a = m_owner ? int'(bus.a1)  : int'(bus.a0);
                m_b = m_owner ? int'(bus.b1)  : int'(bus.b0);
                m_age = 1;
            end
        end else if (m_age == 1) begin
            m_result = (m_a + m_b) % 16;
            if (m_owner) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
            else         m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
            m_age = 2;
        end else begin
            m_prio = !m_owner;
            m_age = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   bus.busy,   32'(m_age != 0));
            chk("gnt0",   bus.gnt0,   32'(m_age != 0 && !m_owner));
            chk("gnt1",   bus.gnt1,   32'(m_age != 0 &&  m_owner));
            chk("done0",  bus.done0,  32'(m_age == 2 && !m_owner));
            chk("done1",  bus.done1,  32'(m_age == 2 &&  m_owner));
            chk("result", bus.result, 32'(m_result));
            chk("alu_s",  alu_s,      32'(m_s));
            chk("alu_a",  alu_a,      32'(m_a));
            chk("alu_b",  alu_b,      32'(m_b));
`ifdef ALU_ARB_STATS_EN
            chk("cnt0",   cnt0,       32'(m_cnt0));
            chk("cnt1",   cnt1,       32'(m_cnt1));
`endif
        end
    end

    int seq [4];
    int stamp [4];
    int n_done;

    initial begin
        bus.req0 = 0; bus.req1 = 0;
        bus.op0 = 3'b010; bus.a0 = 4'd5; bus.b0 = 4'd9;
        bus.op1 = 3'b000; bus.a1 = 4'd0; bus.b1 = 4'd0;
        bus.req0 = 1;
        tick;
        chk_en = 1'b1;
        tick;
        // Reset held with a pending request: everything stays zero.
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_alu_s", alu_s, 0);
        rst_n = 1;
        tick;
        chk("single_gnt0", bus.gnt0, 1);
        chk("single_alu_s", alu_s, 3'b010);
        chk("single_alu_a", alu_a, 5);
        chk("single_alu_b", alu_b, 9);
        bus.a0 = 4'd15;
        tick;
        chk("single_done0", bus.done0, 1);
        chk("single_result", bus.result, 14);
        bus.req0 = 0;
        tick;
        chk("single_idle_gnt0", bus.gnt0, 0);
        chk("single_hold_result", bus.result, 14);

        // Simultaneous requests right after reset: port 0 first.
        rst_n = 0;
        bus.req0 = 1; bus.a0 = 4'd4; bus.b0 = 4'd2;
        bus.req1 = 1; bus.a1 = 4'd1; bus.b1 = 4'd1;
        tick;
        rst_n = 1;
        tick;
        chk("sim_gnt0", bus.gnt0, 1);
        chk("sim_gnt1_low", bus.gnt1, 0);
        tick;
        chk("sim_result0", bus.result, 6);
        bus.req0 = 0;
        tick;
        tick;
        chk("sim_gnt1", bus.gnt1, 1);
        chk("sim_gnt0_low", bus.gnt0, 0);
        tick;
        chk("sim_result1", bus.result, 2);
        bus.req1 = 0;
        tick;

        // Fairness: both keep requesting, dropping only in their done cycle.
        bus.req0 = 1; bus.req1 = 1;
        n_done = 0;
        for (int c = 0; c < 40 && n_done < 4; c++) begin
            tick;
            if (bus.done0 || bus.done1) begin
                seq[n_done] = int'(bus.done1);
                stamp[n_done] = c;
                n_done++;
            end
            bus.req0 = !bus.done0;
            bus.req1 = !bus.done1;
        end
        bus.req0 = 0; bus.req1 = 0;
        chk("fair_ndone", n_done, 4);
        for (int i = 0; i < 4; i++) chk("fair_side", seq[i], i % 2);
        for (int i = 1; i < 4; i++) chk("fair_gap", stamp[i] - stamp[i-1], 3);
        tick;

        // Reset during ISSUE of a port-1 op (prio was 1): no done, prio back to 0.
        bus.req0 = 1;
        tick; tick;
        bus.req0 = 0;
        tick;
        bus.req1 = 1;
        tick;
        chk("mid_gnt1", bus.gnt1, 1);
        rst_n = 0;
        #1;
        chk("mid_gnt1_rst", bus.gnt1, 0);
        chk("mid_busy_rst", bus.busy, 0);
        chk("mid_alu_a_rst", alu_a, 0);
        tick;
        chk("mid_done1", bus.done1, 0);
        rst_n = 1;
        bus.req0 = 1; bus.req1 = 1;
        tick;
        chk("mid_prio_gnt0", bus.gnt0, 1);
        tick;
        bus.req0 = 0; bus.req1 = 0;
        tick;

        // Randomized requesters, with one reset in the middle.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) rst_n = 0;
            if (c == 302) rst_n = 1;
            if (m_age == 2 && !m_owner) bus.req0 = 0;
            else if (m_age != 0 && !m_owner) begin
                if ($urandom_range(3) == 0) bus.a0 = 4'($urandom);
            end else if (bus.req0) begin
                if ($urandom_range(7) == 0) bus.req0 = 0;
            end else if ($urandom_range(1) == 0) begin
                bus.req0 = 1; bus.op0 = 3'($urandom);
                bus.a0 = 4'($urandom); bus.b0 = 4'($urandom);
            end
            if (m_age == 2 && m_owner) bus.req1 = 0;
            else if (m_age != 0 && m_owner) begin
                if ($urandom_range(3) == 0) bus.b1 = 4'($urandom);
            end else if (bus.req1) begin
                if ($urandom_range(7) == 0) bus.req1 = 0;
            end else if ($urandom_range(1) == 0) begin
                bus.req1 = 1; bus.op1 = 3'($urandom);
                bus.a1 = 4'($urandom); bus.b1 = 4'($urandom);
            end
            tick;
        end
        bus.req0 = 0; bus.req1 = 0;
        repeat (4) tick;

`ifdef ALU_ARB_STATS_EN
        rst_n = 0;
        tick;
        rst_n = 1;
        chk("stats_rst_cnt0", cnt0, 0);
        for (int i = 0; i < 300; i++) begin
            bus.req0 = 1;
            tick; tick;
            bus.req0 = 0;
            tick;
        end
        chk("stats_sat_cnt0", cnt0, 255);
        chk("stats_cnt1", cnt1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
